timer_counter_multi: RTL
========================

# timer_counter_multi

Multi-channel programmable interval timer, parametrised successor to the single-channel free-running timer counter. A shared prescaler generates a tick enable, and each of CH independent channels counts ticks up to its own latched terminal value. On reaching that value a channel issues a one-cycle done pulse and either reloads (periodic) or stops (one-shot). It sits beside the other counter blocks as the timing source for anything needing programmable delays or periodic strobes.

## Interface
Parameters:
- N, default 8: channel counter and terminal-value width.
- CH, default 4: number of channels.
- PW, default 4: prescaler width.

Ports:
- clk, input, 1: single clock. All logic is on its rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- prescale, input, PW: tick every prescale+1 clk cycles.
- start, input, CH: per-channel start/restart strobe, 1 cycle.
- stop, input, CH: per-channel abort strobe, 1 cycle.
- mode, input, CH: per channel, 0 = periodic, 1 = one-shot. Sampled at start.
- final_value, input, CH*N: channel i uses bits [i*N +: N]. Sampled at start.
- busy, output, CH: channel in RUN.
- done, output, CH: registered one-cycle pulse at terminal count.
- count, output, CH*N: current channel counts, same packing as final_value.

## Operation
- Prescaler:
  - pcnt counts 0..prescale, then wraps.
  - tick is high in the cycle where pcnt==prescale. prescale=0 gives tick every cycle.
  - Free-running, shared by all channels.
  - A prescale change takes effect at once. If pcnt>prescale, pcnt wraps to 0 on the next edge with no tick.
- Channel FSM states:
  - IDLE (busy=0).
  - RUN (busy=1).
- IDLE:
  - start: latch final_value into fv_q and mode into mode_q, set count=0, go to RUN.
  - All other inputs are ignored.
- RUN, start without stop: restart. Re-latch fv_q and mode_q, set count=0, stay in RUN. No done is issued.
- RUN, stop (takes priority over start and over tick): go to IDLE, set count=0. No done is issued, even on the terminal tick.
- RUN, tick with count!=fv_q: count=count+1.
- RUN, tick with count==fv_q:
  - Assert done on the next edge.
  - Set count=0.
  - Periodic: stay in RUN.
  - One-shot: go to IDLE.
- Period is fv_q+1 ticks. fv_q=0 in periodic mode gives done on every tick.
- Arithmetic:
  - count never exceeds fv_q, so there is no N-bit overflow.
  - fv_q=2^N−1 counts the full range and returns to 0 at terminal.
- Channels are fully independent. Simultaneous events on different channels never interact.
- Changing final_value or mode while in RUN has no effect until the next start.

## Timing
- Reset values:
  - pcnt=0.
  - All channels in IDLE.
  - busy=0, done=0, count=0, fv_q=0, mode_q=0.
- Reset asserted mid-count forces the reset values immediately, including any in-flight done.
- start at edge k: busy=1 and count=0 from edge k.
- First increment happens at the first tick edge after k.
- done rises on the edge that processes the terminal tick and falls one cycle later.
- For one-shot, busy falls on that same edge.
- stop at edge k: busy=0 and count=0 from edge k.
- With prescale=0, one-shot, final_value=F: done appears F+1 cycles after the start edge.

## Structure
- Package timer_pkg holds:
  - mode constants MODE_PERIODIC=1'b0 and MODE_ONESHOT=1'b1.
  - channel state encoding ST_IDLE and ST_RUN.
- Sub-module timer_channel (parameter N) contains:
  - the per-channel FSM, fv_q, mode_q, count and the done register.
  - inputs: clk, reset_n, tick, start, stop, mode, final_value.
  - outputs: busy, done, count.
- Top level contains the prescaler and a generate loop instantiating CH timer_channel copies.

## Test plan
- Reset, then prescale=0, ch0 one-shot, final_value=3, start.
  - Required: count 0,1,2,3, then done pulse of 1 cycle, busy falls, count=0.
  - done is 4 cycles after start.
- prescale=2, ch1 periodic, final_value=1.
  - Required: tick every 3 cycles.
  - done every 6 cycles, 1 cycle wide, busy stays 1.
- ch2 periodic, final_value=0, prescale=0.
  - Required: done high on every cycle after start.
- ch0 running at count=5 of 9: assert stop and start together.
  - Required: stop wins, IDLE, count=0, no done.
  - Then start alone at count=5: restart to 0, next done 10 ticks later.
- final_value=255 with N=8: full range, then wrap to 0 with done.
  - Meanwhile, start ch3 on the same cycle as ch0's terminal tick.
  - Required: the two channels are independent and correct.
- Assert reset_n low mid-count on all channels, asynchronously and between edges.
  - Required: busy=0, done=0, count=0 immediately.

Source files
------------

// File: rtl/timer_counter_multi_pkg.sv
// Shared constants for the multi-channel interval timer: channel mode values
// and the channel state encoding.
package timer_pkg;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_e;

endpackage

// File: rtl/timer_counter_multi_if.sv
// Control/status bundle of the multi-channel timer: the master drives configuration
// and strobes, the slave (the timer) returns per-channel status and counts.
interface timer_counter_multi_if #(
    parameter int N  = 8,
    parameter int CH = 4,
    parameter int PW = 4
);
    logic [PW-1:0]   prescale;
    logic [CH-1:0]   start;
    logic [CH-1:0]   stop;
    logic [CH-1:0]   mode;
    logic [CH*N-1:0] final_value;
    logic [CH-1:0]   busy;
    logic [CH-1:0]   done;
    logic [CH*N-1:0] count;

    modport master (
        output prescale, start, stop, mode, final_value,
        input  busy, done, count
    );

    modport slave (
        input  prescale, start, stop, mode, final_value,
        output busy, done, count
    );
endinterface

// File: rtl/timer_counter_multi_channel.sv
// One timer channel: counts prescaler ticks up to a terminal value latched at start,
// pulses done on the terminal tick, then reloads (periodic) or stops (one-shot).
module timer_channel
    import timer_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         tick,
    input  logic         start,
    input  logic         stop,
    input  logic         mode,
    input  logic [N-1:0] final_value,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] count
);

    ch_state_e    state_q, state_d;
    logic [N-1:0] fv_q, fv_d;
    logic [N-1:0] count_q, count_d;
    logic         mode_q, mode_d;
    logic         done_q, done_d;

    // Next-state and datapath: stop outranks start, which outranks a tick.
    always_comb begin
        state_d = state_q;
        fv_d    = fv_q;
        count_d = count_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    fv_d    = final_value;
                    mode_d  = mode;
                    count_d = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    count_d = '0;
                    state_d = ST_IDLE;
                end else if (start) begin
                    fv_d    = final_value;
                    mode_d  = mode;
                    count_d = '0;
                end else if (tick) begin
                    if (count_q == fv_q) begin
                        done_d  = 1'b1;
                        count_d = '0;
                        if (mode_q == MODE_ONESHOT) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        count_d = count_q + N'(1);
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                count_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Channel state registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            fv_q    <= '0;
            count_q <= '0;
            mode_q  <= MODE_PERIODIC;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fv_q    <= fv_d;
            count_q <= count_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    assign busy  = (state_q == ST_RUN);
    assign done  = done_q;
    assign count = count_q;

endmodule

// File: rtl/timer_counter_multi.sv
// Multi-channel interval timer: one free-running prescaler shared by CH
// independent timer_channel instances.
module timer_counter_multi
    import timer_pkg::*;
#(
    parameter int N  = 8,
    parameter int CH = 4,
    parameter int PW = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    timer_counter_multi_if.slave  bus
);

    logic [PW-1:0]   pcnt_q, pcnt_d;
    logic            tick_s;
    logic [CH-1:0]   busy_s;
    logic [CH-1:0]   done_s;
    logic [CH*N-1:0] count_s;

    // A lowered prescale can leave pcnt above it; that wraps to 0 without a tick.
    always_comb begin
        tick_s = (pcnt_q == bus.prescale);
        if (pcnt_q >= bus.prescale) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + PW'(1);
        end
    end

    // Prescaler counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        timer_channel #(.N(N)) u_ch (
            .clk         (clk),
            .reset_n     (reset_n),
            .tick        (tick_s),
            .start       (bus.start[i]),
            .stop        (bus.stop[i]),
            .mode        (bus.mode[i]),
            .final_value (bus.final_value[i*N +: N]),
            .busy        (busy_s[i]),
            .done        (done_s[i]),
            .count       (count_s[i*N +: N])
        );
    end

    assign bus.busy  = busy_s;
    assign bus.done  = done_s;
    assign bus.count = count_s;

endmodule
